serial_adder8: RTL and testbench

- Bit-serial multi-bit adder built around the single-bit full adder.
- Each cycle it feeds one operand bit pair plus the registered carry into the full adder, then captures the sum bit and carry-out.
- Produces a WIDTH-bit sum, carry-out and signed overflow through a start/busy/done handshake.
- Sits between operand registers and the processor's ALU result path as a low-area add engine.

---
 rtl/serial_adder8_if.sv | 25 ++
 rtl/serial_adder8.sv | 95 +++++++++
 tb/tb_serial_adder8.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_adder8_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// master = requester (drives operands and start), slave = adder engine.
interface serial_adder8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder8.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first.
// A start in IDLE or DONE latches the operands; the result (sum, carry-out,
// signed overflow) is published on the final-bit edge alongside a 1-cycle done.
module serial_adder8 #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder8_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, ssum;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r, overflow_r;

    logic             fa_s, fa_co, last;
    logic [WIDTH-1:0] ssum_next;
    logic             accept;

    // Full adder on the current LSB pair plus the registered carry.
    always_comb begin
        fa_s      = 1'b0;
        fa_co     = 1'b0;
        fa_s      = sa[0] ^ sb[0] ^ cy;
        fa_co     = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));
        ssum_next = {fa_s, ssum[WIDTH-1:1]};
        last      = (cnt == CW'(WIDTH - 1));
        accept    = bus.start && (state == IDLE || state == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: start only counts outside SHIFT, so a start while busy is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, serial datapath and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            ssum       <= '0;
            cy         <= 1'b0;
            cnt        <= '0;
            sum_r      <= '0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept) begin
            sa   <= bus.a;
            sb   <= bus.b;
            cy   <= bus.c_in;
            cnt  <= '0;
            ssum <= '0;
        end else if (state == SHIFT) begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            ssum <= ssum_next;
            cy   <= fa_co;
            cnt  <= cnt + CW'(1);
            if (last) begin
                // cy still holds the carry into the MSB on this edge.
                sum_r      <= ssum_next;
                c_out_r    <= fa_co;
                overflow_r <= cy ^ fa_co;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_serial_adder8.sv
// Directed bench for serial_adder8: hand-computed vectors, hold/ignore,
// back-to-back restart and asynchronous mid-operation reset.
module tb_serial_adder8;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_adder8_if #(.WIDTH(WIDTH)) bus ();

    serial_adder8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from the current cycle and follow it to done.
    // poke: fire a spurious start with new operands mid-SHIFT and check hold.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] es, input logic ec,
                          input logic eo, input bit poke);
        int nb;
        int guard;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.c_in  = ci;
        step();
        bus.start = 1'b0;
        chk({tag, "_busy_first"}, 32'(bus.busy), 32'd1);
        nb    = 0;
        guard = 0;
        while (!bus.done && guard < 20) begin
            if (bus.busy) nb++;
            if (poke && nb == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
                bus.c_in  = 1'b1;
                chk({tag, "_hold_sum"}, 32'(bus.sum), 32'h00);
                chk({tag, "_hold_cout"}, 32'(bus.c_out), 32'd1);
            end else if (poke && nb == 4) begin
                bus.start = 1'b0;
                bus.a     = 8'hA5;
                bus.b     = 8'h5A;
                bus.c_in  = 1'b0;
            end
            step();
            guard++;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
    endtask

    initial begin
        int dn;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.c_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        step();

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        chk("zero_done_drop", 32'(bus.done), 32'd0);
        chk("zero_idle_busy", 32'(bus.busy), 32'd0);

        run_op("ff_p1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        run_op("7f_p1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        step();
        run_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step();
        run_op("55_aa_c", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        step();

        // Spurious start during SHIFT must not disturb 0x12+0x34.
        run_op("hold", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        // Restart in the DONE cycle: run_op checks busy right after accept.
        run_op("b2b", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset between edges, 4 cycles into SHIFT.
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.c_in  = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        chk("mid_sum", 32'(bus.sum), 32'd0);
        chk("mid_cout", 32'(bus.c_out), 32'd0);
        chk("mid_ovf", 32'(bus.overflow), 32'd0);
        step();
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            step();
            if (bus.done) dn++;
        end
        chk("mid_no_done", 32'(dn), 32'd0);
        chk("mid_sum_after", 32'(bus.sum), 32'd0);

        run_op("fresh", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
